// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR opcodes, addresses, field masks and read-modify-write helper
package csr_pkg;

  typedef enum logic [2:0] {
    CSROP_NONE = 3'b000,
    CSRRW      = 3'b001,
    CSRRS      = 3'b010,
    CSRRC      = 3'b011,
    CSRRWI     = 3'b101,
    CSRRSI     = 3'b110,
    CSRRCI     = 3'b111
  } csrop_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam logic [31:0] MSTATUS_WMASK   = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_RO_ONES = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK       = 32'h0000_0888;

  function automatic csrop_t gen_csrop_f(input logic [2:0] funct3);
    case (funct3)
      3'b001:  return CSRRW;
      3'b010:  return CSRRS;
      3'b011:  return CSRRC;
      3'b101:  return CSRRWI;
      3'b110:  return CSRRSI;
      3'b111:  return CSRRCI;
      default: return CSROP_NONE;
    endcase
  endfunction

  function automatic logic [31:0] csr_rmw_f(input logic [31:0] old_v,
                                            input logic [31:0] src,
                                            input csrop_t op);
    case (op[1:0])
      2'b01:   return src;
      2'b10:   return old_v | src;
      2'b11:   return old_v & ~src;
      default: return old_v;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit free-running counter with per-half CSR load
// A load of either half takes precedence over the increment in that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo_i)      count_d[31:0]  = wdata_i;
    else if (wr_hi_i) count_d[63:32] = wdata_i;
    else if (inc_i)   count_d        = count_q + 64'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file, trap entry/return and redirect
// Optional cycle/instret counters are built when CSR_COUNTERS_EN is defined.
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en_i,
  input  csrop_t          csrop_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [4:0]      rs1_zimm_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            illegal_o,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_val_i,
  input  logic            mret_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [31:0] src, old_val, new_val, mst_bits, mstatus_rd;
  logic        impl, wr_req, illegal, csr_wr;

  assign src    = csrop_i[2] ? {27'b0, rs1_zimm_i} : rs1_data_i;
  // Set/clear forms with a zero rs1 field are pure reads.
  assign wr_req = (csrop_i[1:0] == 2'b01) ||
                  ((csrop_i[1:0] != 2'b00) && (rs1_zimm_i != 5'd0));

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (csr_wr && (csr_addr_i == CSR_MCYCLE)),
    .wr_hi_i (csr_wr && (csr_addr_i == CSR_MCYCLEH)),
    .wdata_i (new_val),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (retire_i),
    .wr_lo_i (csr_wr && (csr_addr_i == CSR_MINSTRET)),
    .wr_hi_i (csr_wr && (csr_addr_i == CSR_MINSTRETH)),
    .wdata_i (new_val),
    .count_o (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  always_comb begin
    mst_bits                   = '0;
    mst_bits[MSTATUS_MIE_BIT]  = st_mie_q;
    mst_bits[MSTATUS_MPIE_BIT] = st_mpie_q;
    mstatus_rd                 = MSTATUS_RO_ONES | (mst_bits & MSTATUS_WMASK);
    impl    = 1'b1;
    old_val = '0;
    case (csr_addr_i)
      CSR_MSTATUS:  old_val = mstatus_rd;
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MTVAL:    old_val = mtval_q;
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: old_val = '0;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,    CSR_CYCLE:    old_val = mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   old_val = mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  old_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
`endif
      default: impl = 1'b0;
    endcase
  end

  assign illegal = csr_en_i && (!impl || ((csr_addr_i[11:10] == 2'b11) && wr_req));
  assign csr_wr  = csr_en_i && !illegal && wr_req && !trap_i && !mret_i;
  assign new_val = csr_rmw_f(old_val, src, csrop_i);

  assign csr_rdata_o   = (csr_en_i && !illegal) ? old_val : '0;
  assign illegal_o     = illegal;
  assign redirect_o    = !rst && (trap_i || mret_i);
  assign redirect_pc_o = !redirect_o ? '0 : (trap_i ? {mtvec_q[31:2], 2'b00} : mepc_q);

  // Trap beats MRET beats CSR write; lower-priority updates are simply dropped.
  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_i) begin
      mepc_d    = trap_pc_i & ~32'h3;
      mcause_d  = trap_cause_i;
      mtval_d   = trap_val_i;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (mret_i) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (csr_wr) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          st_mie_d  = new_val[MSTATUS_MIE_BIT];
          st_mpie_d = new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = new_val & MIE_WMASK;
        CSR_MTVEC:    mtvec_d    = new_val & ~32'h3;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val & ~32'h3;
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= {MTVEC_RST[31:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - directed and randomized checks of csr_unit against a table-driven model
// Counter checks follow CSR_COUNTERS_EN.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        csr_en, illegal, retire, trap, mret, redirect;
  csrop_t      csrop;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data, rdata, trap_cause, trap_pc, trap_val, redirect_pc;
  logic [4:0]  zimm;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(32), .MTVEC_RST(32'h0)) dut (
    .clk(clk), .rst(rst), .csr_en_i(csr_en), .csrop_i(csrop), .csr_addr_i(csr_addr),
    .rs1_data_i(rs1_data), .rs1_zimm_i(zimm), .csr_rdata_o(rdata), .illegal_o(illegal),
    .retire_i(retire), .trap_i(trap), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
    .trap_val_i(trap_val), .mret_i(mret), .redirect_o(redirect), .redirect_pc_o(redirect_pc)
  );

`ifdef CSR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_cmp = 0, n_err = 0;
  logic [31:0] mdl [int];
  logic [63:0] m_cyc, m_ins, nc, ni;
  logic [31:0] last_rd, last_pc, g_old;
  logic        last_ill, g_wr, g_ill;

  localparam int NADDR = 23;
  logic [11:0] addr_list [NADDR] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'h343, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
    12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'h301, 12'h7C0, 12'h344, 12'hB01};
  csrop_t ops [6] = '{CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};

  function automatic bit is_cnt(int a);
    return a inside {'hB00, 'hB02, 'hB80, 'hB82, 'hC00, 'hC02, 'hC80, 'hC82};
  endfunction

  function automatic logic [31:0] wmask_f(int a);
    case (a)
      'h300: return 32'h0000_0088;
      'h304: return 32'h0000_0888;
      'h305, 'h341: return 32'hFFFF_FFFC;
      'h340, 'h342, 'h343: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_impl(int a);
    return mdl.exists(a) || (CNT_EN && is_cnt(a));
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (mdl.exists(a)) return mdl[a] | ((a == 'h300) ? 32'h1800 : 32'h0);
    case (a)
      'hB00, 'hC00: return m_cyc[31:0];
      'hB80, 'hC80: return m_cyc[63:32];
      'hB02, 'hC02: return m_ins[31:0];
      'hB82, 'hC82: return m_ins[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    mdl.delete();
    foreach (addr_list[i]) if (addr_list[i] inside {[12'h300:12'h343], [12'hF11:12'hF14]}
                                && wmask_f(int'(addr_list[i])) != 0 || addr_list[i] inside {[12'hF11:12'hF14]})
      mdl[int'(addr_list[i])] = 32'h0;
    m_cyc = 64'd0;
    m_ins = 64'd0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    csr_en = 0; csrop = CSRRS; csr_addr = 12'h0; rs1_data = 0; zimm = 0;
    retire = 0; trap = 0; mret = 0; trap_cause = 0; trap_pc = 0; trap_val = 0;
  endtask

  task automatic set_op(csrop_t op, logic [11:0] a, logic [31:0] r, logic [4:0] z);
    csr_en = 1; csrop = op; csr_addr = a; rs1_data = r; zimm = z;
  endtask

  task automatic check_now(string tag);
    int a;
    logic [31:0] e_rd, e_pc;
    logic e_red;
    a     = int'(csr_addr);
    g_old = m_read(a);
    g_wr  = csr_en && (csrop == CSRRW || csrop == CSRRWI || zimm != 0);
    g_ill = csr_en && (!m_impl(a) || (csr_addr[11:10] == 2'b11 && g_wr));
    e_rd  = (csr_en && !g_ill) ? g_old : 32'h0;
    e_red = !rst && (trap || mret);
    e_pc  = !e_red ? 32'h0 : (trap ? mdl['h305] : mdl['h341]);
    chk({tag, ".rdata"}, rdata, e_rd);
    chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, g_ill});
    chk({tag, ".redirect"}, {31'b0, redirect}, {31'b0, e_red});
    chk({tag, ".redirect_pc"}, redirect_pc, e_pc);
    last_rd = rdata; last_ill = illegal; last_pc = redirect_pc;
  endtask

  task automatic model_update();
    int a;
    logic [31:0] src, nv, mst, nm;
    a  = int'(csr_addr);
    nc = m_cyc + 64'd1;
    ni = retire ? m_ins + 64'd1 : m_ins;
    if (trap) begin
      mst = mdl['h300]; nm = 32'h0; nm[7] = mst[3];
      mdl['h300] = nm;
      mdl['h341] = trap_pc & ~32'h3;
      mdl['h342] = trap_cause;
      mdl['h343] = trap_val;
    end else if (mret) begin
      mst = mdl['h300]; nm = 32'h0; nm[3] = mst[7]; nm[7] = 1'b1;
      mdl['h300] = nm;
    end else if (g_wr && !g_ill) begin
      src = (csrop inside {CSRRWI, CSRRSI, CSRRCI}) ? {27'b0, zimm} : rs1_data;
      if (csrop inside {CSRRW, CSRRWI})      nv = src;
      else if (csrop inside {CSRRS, CSRRSI}) nv = g_old | src;
      else                                   nv = g_old & ~src;
      if (mdl.exists(a)) mdl[a] = nv & wmask_f(a);
      else if (a == 'hB00) nc = {m_cyc[63:32], nv};
      else if (a == 'hB80) nc = {nv, m_cyc[31:0]};
      else if (a == 'hB02) ni = {m_ins[63:32], nv};
      else if (a == 'hB82) ni = {nv, m_ins[31:0]};
    end
  endtask

  task automatic step(string tag);
    #2;
    check_now(tag);
    model_update();
    @(posedge clk);
    #1;
    m_cyc = nc;
    m_ins = ni;
  endtask

  initial begin
    idle();
    m_reset();
    @(posedge clk); #1;
    rst = 0;
    step("reset_idle");
    set_op(CSRRS, 12'h300, 32'h0, 5'd0); step("mstatus_rst");
    chk("mstatus_rst_val", last_rd, 32'h0000_1800);

    set_op(CSRRW, 12'h340, 32'hDEADBEEF, 5'd1); step("mscratch_rw");
    chk("mscratch_rw_old", last_rd, 32'h0);
    set_op(CSRRS, 12'h340, 32'h0000000F, 5'd1); step("mscratch_rs");
    chk("mscratch_rs_old", last_rd, 32'hDEADBEEF);
    set_op(CSRRS, 12'h340, 32'h0, 5'd0); step("mscratch_rd");
    chk("mscratch_final", last_rd, 32'hDEADBEEF);

    set_op(CSRRW, 12'h300, 32'hFFFF_FFFF, 5'd1); step("mstatus_w");
    set_op(CSRRC, 12'h300, 32'hFFFF_FFFF, 5'd0); step("mstatus_rc0");
    chk("rc0_rdata", last_rd, 32'h0000_1888);
    chk("rc0_illegal", {31'b0, last_ill}, 32'h0);
    set_op(CSRRS, 12'h300, 32'h0, 5'd0); step("mstatus_after_rc0");
    chk("rc0_nowrite", last_rd, 32'h0000_1888);

    set_op(CSRRWI, 12'hF14, 32'h0, 5'd1); step("mhartid_wi");
    chk("mhartid_wi_illegal", {31'b0, last_ill}, 32'h1);
    set_op(CSRRSI, 12'hF14, 32'h0, 5'd0); step("mhartid_rd");
    chk("mhartid_rd_legal", {31'b0, last_ill}, 32'h0);

    set_op(CSRRW, 12'h305, 32'h8000_0003, 5'd1); step("mtvec_w");
    idle(); trap = 1; trap_cause = 32'h2; trap_pc = 32'h104; trap_val = 32'h13;
    step("trap");
    chk("trap_target", last_pc, 32'h8000_0000);
    idle(); set_op(CSRRS, 12'h341, 32'h0, 5'd0); step("mepc_rd");
    chk("trap_mepc", last_rd, 32'h104);
    set_op(CSRRS, 12'h342, 32'h0, 5'd0); step("mcause_rd");
    chk("trap_mcause", last_rd, 32'h2);
    set_op(CSRRS, 12'h300, 32'h0, 5'd0); step("mstatus_trap");
    chk("trap_mstatus", last_rd, 32'h0000_1880);
    idle(); mret = 1; step("mret");
    chk("mret_target", last_pc, 32'h104);
    idle(); set_op(CSRRS, 12'h300, 32'h0, 5'd0); step("mstatus_mret");
    chk("mret_mstatus", last_rd, 32'h0000_1888);

    set_op(CSRRW, 12'h340, 32'hCAFE_0000, 5'd1);
    trap = 1; mret = 1; trap_cause = 32'h7; trap_pc = 32'h20B; trap_val = 32'h0;
    step("trap_mret");
    chk("trap_wins_target", last_pc, 32'h8000_0000);
    idle(); set_op(CSRRS, 12'h340, 32'h0, 5'd0); step("mscratch_kept");
    chk("trap_drops_write", last_rd, 32'hDEADBEEF);
    set_op(CSRRS, 12'h341, 32'h0, 5'd0); step("mepc_align");
    chk("trap_mepc_align", last_rd, 32'h208);

    if (CNT_EN) begin
      set_op(CSRRW, 12'hB00, 32'hFFFF_FFFF, 5'd1); step("mcycle_w");
      set_op(CSRRW, 12'hB80, 32'hFFFF_FFFF, 5'd1); step("mcycleh_w");
      idle(); step("cyc_idle");
      set_op(CSRRS, 12'hB00, 32'h0, 5'd0); step("mcycle_rd");
      chk("mcycle_wrap_lo", last_rd, 32'h0);
      set_op(CSRRS, 12'hB80, 32'h0, 5'd0); step("mcycleh_rd");
      chk("mcycle_wrap_hi", last_rd, 32'h0);
      idle(); retire = 1;
      for (int i = 0; i < 5; i++) step("retire");
      idle(); set_op(CSRRS, 12'hB02, 32'h0, 5'd0); step("minstret_rd");
      chk("minstret_5", last_rd, 32'h5);
      set_op(CSRRW, 12'hC00, 32'h1, 5'd1); step("cycle_shadow_w");
      chk("cycle_shadow_ro", {31'b0, last_ill}, 32'h1);
    end else begin
      for (int i = 11; i < 19; i++) begin
        set_op(CSRRS, addr_list[i], 32'h0, 5'd0); step("cnt_absent");
        chk("cnt_absent_illegal", {31'b0, last_ill}, 32'h1);
      end
    end

    for (int i = 0; i < 300; i++) begin
      idle();
      if ($urandom_range(3) != 0)
        set_op(ops[$urandom_range(5)], addr_list[$urandom_range(NADDR - 1)], $urandom,
               ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom));
      retire = 1'($urandom);
      trap   = ($urandom_range(15) == 0);
      mret   = ($urandom_range(15) == 0);
      trap_cause = $urandom; trap_pc = $urandom; trap_val = $urandom;
      step("rand");
    end

    idle();
    set_op(CSRRW, 12'h340, 32'h1234_5678, 5'd1);
    trap = 1; trap_cause = 32'h5; trap_pc = 32'h400;
    #2; rst = 1; #1;
    m_reset();
    check_now("rst_mid_trap");
    trap = 0;
    foreach (addr_list[i]) begin
      set_op(CSRRS, addr_list[i], 32'h0, 5'd0);
      #1;
      check_now("rst_values");
    end
    @(posedge clk); #1;
    rst = 0;
    idle();
    set_op(CSRRS, 12'h340, 32'h0, 5'd0); step("post_rst_mscratch");
    chk("post_rst_mscratch_val", last_rd, 32'h0);
    set_op(CSRRS, 12'h300, 32'h0, 5'd0); step("post_rst_mstatus");
    chk("post_rst_mstatus_val", last_rd, 32'h0000_1800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
